// File: rtl/add_share_arb.sv
// Round-robin arbiter that shares one LAT-stage adder among NREQ requesters.
// Results are tagged with the requester ID and queued in an in-order response FIFO.
module add_share_arb #(
    parameter int W     = 15,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int LAT   = 2,
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_x,
    input  logic [NREQ*W-1:0]   req_y,
    output logic [W-1:0]        add_x,
    output logic [W-1:0]        add_y,
    input  logic [W-1:0]        add_sum,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [W-1:0]        rsp_sum,
    output logic                busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  r_rr_ptr;
    logic [LAT:0]     r_vld_p;
    logic [ID_W-1:0]  r_id_p [LAT+1];
    logic [W-1:0]     r_add_x_p0;
    logic [W-1:0]     r_add_y_p0;
    logic [ID_W-1:0]  r_mem_id  [DEPTH];
    logic [W-1:0]     r_mem_sum [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [W-1:0]     w_x_arr [NREQ];
    logic [W-1:0]     w_y_arr [NREQ];
    int               w_inflight;
    logic             w_credit;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_gid;
    logic             w_found;
    logic [NREQ-1:0]  w_grant;
    logic             w_xfer;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_x_arr[i] = req_x[i*W +: W];
            w_y_arr[i] = req_y[i*W +: W];
        end
    end

    // Every tag still in the adder pipe has a FIFO slot reserved for it.
    always_comb begin
        w_inflight = 0;
        for (int k = 0; k <= LAT; k++) begin
            w_inflight = w_inflight + int'(r_vld_p[k]);
        end
        w_credit = (int'(r_count) + w_inflight) < DEPTH;
    end

    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = '0;
        w_grant = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gid   = w_idx;
            end
        end
        if (w_found && w_credit) begin
            w_grant[w_gid] = 1'b1;
        end
    end

    assign w_xfer    = w_found & w_credit;
    assign w_push    = r_vld_p[LAT];
    assign w_pop     = rsp_valid & rsp_ready;
    assign req_ready = w_grant;

    // Stage p0: operand register feeding the adder, plus all control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= ID_W'(NREQ - 1);
            r_vld_p    <= '0;
            r_add_x_p0 <= '0;
            r_add_y_p0 <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_vld_p <= {r_vld_p[LAT-1:0], w_xfer};
            if (w_xfer) begin
                r_rr_ptr   <= w_gid;
                r_add_x_p0 <= w_x_arr[w_gid];
                r_add_y_p0 <= w_y_arr[w_gid];
            end
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Stages p1..p(LAT+1): ID tags travel alongside the adder; last stage meets add_sum.
    always_ff @(posedge clk) begin
        r_id_p[0] <= w_gid;
        for (int k = 1; k <= LAT; k++) begin
            r_id_p[k] <= r_id_p[k-1];
        end
        if (w_push) begin
            r_mem_id[r_wr_ptr]  <= r_id_p[LAT];
            r_mem_sum[r_wr_ptr] <= add_sum;
        end
    end

    assign add_x     = r_add_x_p0;
    assign add_y     = r_add_y_p0;
    assign rsp_valid = (r_count != '0);
    assign rsp_id    = rsp_valid ? r_mem_id[r_rd_ptr]  : '0;
    assign rsp_sum   = rsp_valid ? r_mem_sum[r_rd_ptr] : '0;
    assign busy      = (|r_vld_p) | rsp_valid;

endmodule
